// File: rtl/rom_arb_pkg.sv
// Shared constants and the tag type for the two-port character/pattern ROM arbiter.
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam int ROM_LAT  = 1;
  localparam int PIPE_LAT = 2;

  localparam logic PORT_VGA = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, port: 1'b0};

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and ROM bus of the ROM arbiter; the arbiter takes the slave modport,
// the requesters plus the ROM take the master modport.
interface rom_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

endinterface

// File: rtl/rom_arb_pick.sv
// Request selector for the ROM arbiter: fixed priority (port 0 wins) by default,
// round-robin with a last-served pointer when ROM_ARB_RR_EN is defined.
module rom_arb_pick
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic clk,
`endif
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ROM_ARB_RR_EN
  logic last_q;
  logic last_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        // Contention goes to whichever port was not served last.
        if (last_q == PORT_AUX) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = PORT_VGA;
    end else if (gnt1) begin
      last_d = PORT_AUX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_AUX;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0;
      gnt1 = req1 && !req0;
    end
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a single-port registered ROM; fixed 2-cycle
// grant-to-data latency. Define ROM_ARB_RR_EN for round-robin arbitration.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus
);

  logic              gnt0;
  logic              gnt1;

  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  tag_t              tag_p1_q;
  tag_t              tag_p1_d;
  tag_t              tag_p2_q;
  tag_t              tag_p2_d;
  logic [DATA_W-1:0] rdata_p2;

  rom_arb_pick u_pick (
`ifdef ROM_ARB_RR_EN
    .clk  (clk),
`endif
    .rst  (rst),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Stage p0 -> p1: granted address goes to the ROM, tag records the owner.
  always_comb begin
    rom_addr_d = rom_addr_q;
    tag_p1_d   = TAG_IDLE;
    if (gnt0) begin
      rom_addr_d = bus.addr0;
      tag_p1_d   = '{valid: 1'b1, port: PORT_VGA};
    end else if (gnt1) begin
      rom_addr_d = bus.addr1;
      tag_p1_d   = '{valid: 1'b1, port: PORT_AUX};
    end
  end

  // Stage p1 -> p2: tag follows the ROM's internal data register.
  always_comb begin
    tag_p2_d = tag_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      tag_p1_q   <= TAG_IDLE;
      tag_p2_q   <= TAG_IDLE;
    end else begin
      rom_addr_q <= rom_addr_d;
      tag_p1_q   <= tag_p1_d;
      tag_p2_q   <= tag_p2_d;
    end
  end

  // Stage p2: ROM data is valid, steer the strobe to the tagged port.
  assign rdata_p2    = bus.rom_data;

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rom_addr = rom_addr_q;

  assign bus.rvalid0 = tag_p2_q.valid && (tag_p2_q.port == PORT_VGA);
  assign bus.rvalid1 = tag_p2_q.valid && (tag_p2_q.port == PORT_AUX);
  assign bus.rdata0  = rdata_p2;
  assign bus.rdata1  = rdata_p2;

endmodule
